// File: rtl/neuro_pkg.sv
// Shared types and helpers for the neuromorphic signal chain (neurons, synapses, decoders).
package neuro_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } rate_dec_state_t;

  localparam int SAT_W = 32;

  // Increment by inc, clamping at maxv; callers zero-extend narrower counters to SAT_W.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] a,
                                               input logic             inc,
                                               input logic [SAT_W-1:0] maxv);
    if (inc && (a < maxv)) begin
      sat_inc = a + SAT_W'(1);
    end else begin
      sat_inc = a;
    end
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Valid/ready output channel carrying one window spike count and its saturation flag.
interface spike_rate_decoder_if #(
  parameter int CNT_W = 8
);

  logic [CNT_W-1:0] rate_out;
  logic             rate_sat;
  logic             rate_valid;
  logic             rate_ready;

  modport master (
    output rate_out,
    output rate_sat,
    output rate_valid,
    input  rate_ready
  );

  modport slave (
    input  rate_out,
    input  rate_sat,
    input  rate_valid,
    output rate_ready
  );

endinterface

// File: rtl/spike_rate_decoder_timer.sv
// Window timer: IDLE/COUNT state and the in-window cycle counter for the rate decoder.
module spike_window_timer
  import neuro_pkg::*;
#(
  parameter int WINDOW = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic counting,
  output logic window_close
);

  localparam int              WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] LAST = WIN_W'(WINDOW - 1);

  rate_dec_state_t  state_q;
  logic [WIN_W-1:0] win_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          win_cnt_q <= '0;
          if (enable) state_q <= COUNT;
        end
        COUNT: begin
          if (!enable) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
          end else if (win_cnt_q == LAST) begin
            win_cnt_q <= '0;
          end else begin
            win_cnt_q <= win_cnt_q + WIN_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          win_cnt_q <= '0;
        end
      endcase
    end
  end

  // A cycle where enable has just dropped is already part of the discarded window.
  assign counting     = (state_q == COUNT) && enable;
  assign window_close = counting && (win_cnt_q == LAST);

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per fixed window, buffers each count on a valid/ready channel and tracks an EMA.
module spike_rate_decoder
  import neuro_pkg::*;
#(
  parameter int WINDOW    = 256,
  parameter int CNT_W     = 8,
  parameter int AVG_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  spike_in,
  spike_rate_decoder_if.master  rate_if,
  output logic [CNT_W-1:0]      avg_out,
  output logic                  overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               EW      = CNT_W + 1;

  logic counting;
  logic window_close;

  spike_window_timer #(
    .WINDOW(WINDOW)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .counting     (counting),
    .window_close (window_close)
  );

  logic [CNT_W-1:0]     spike_cnt_q, spike_cnt_d;
  logic                 sat_q, sat_d;
  logic [CNT_W-1:0]     inc_cnt;
  logic                 sample_sat;
  logic [CNT_W-1:0]     rate_q, rate_d;
  logic                 rate_sat_q, rate_sat_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     avg_q, avg_d;
  logic                 overrun_q, overrun_d;
  logic                 consume;
  logic                 load;
  logic signed [EW-1:0] err;
  logic signed [EW-1:0] err_shift;
  logic signed [EW-1:0] avg_next;

  always_comb begin
    inc_cnt    = CNT_W'(sat_inc(SAT_W'(spike_cnt_q), spike_in, SAT_W'(CNT_MAX)));
    sample_sat = sat_q | (spike_in && (spike_cnt_q == CNT_MAX));

    spike_cnt_d = inc_cnt;
    sat_d       = sample_sat;
    if (!counting || window_close) begin
      spike_cnt_d = '0;
      sat_d       = 1'b0;
    end

    // Consuming and loading in one cycle lets a new sample replace a full buffer.
    consume    = valid_q && rate_if.rate_ready;
    load       = window_close && (!valid_q || consume);
    rate_d     = rate_q;
    rate_sat_d = rate_sat_q;
    valid_d    = valid_q && !consume;
    if (load) begin
      rate_d     = inc_cnt;
      rate_sat_d = sample_sat;
      valid_d    = 1'b1;
    end
    overrun_d = overrun_q | (window_close && !load);

    // The result always lies between the old average and the sample; the clamp is a guard.
    err       = $signed({1'b0, inc_cnt}) - $signed({1'b0, avg_q});
    err_shift = err >>> AVG_SHIFT;
    avg_next  = $signed({1'b0, avg_q}) + err_shift;
    avg_d     = avg_q;
    if (window_close) begin
      if (avg_next < 0) begin
        avg_d = '0;
      end else if (avg_next > $signed({1'b0, CNT_MAX})) begin
        avg_d = CNT_MAX;
      end else begin
        avg_d = avg_next[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spike_cnt_q <= '0;
      sat_q       <= 1'b0;
      rate_q      <= '0;
      rate_sat_q  <= 1'b0;
      valid_q     <= 1'b0;
      avg_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      spike_cnt_q <= spike_cnt_d;
      sat_q       <= sat_d;
      rate_q      <= rate_d;
      rate_sat_q  <= rate_sat_d;
      valid_q     <= valid_d;
      avg_q       <= avg_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rate_if.rate_out   = rate_q;
  assign rate_if.rate_sat   = rate_sat_q;
  assign rate_if.rate_valid = valid_q;
  assign avg_out            = avg_q;
  assign overrun            = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed self-checking bench for spike_rate_decoder with hand-computed counts and EMA values.
module tb_spike_rate_decoder;

  localparam int WINDOW     = 256;
  localparam int CNT_W      = 8;
  localparam int AVG_SHIFT  = 2;
  localparam int SPK_LOW    = 0;
  localparam int SPK_EVERY8 = 1;
  localparam int SPK_HIGH   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             spike_in;
  logic [CNT_W-1:0] avg_out;
  logic             overrun;

  int checkCount = 0;
  int errorCount = 0;
  int phaseCnt   = 0;
  int spikeMode  = SPK_LOW;

  spike_rate_decoder_if #(.CNT_W(CNT_W)) rate_if ();

  spike_rate_decoder #(
    .WINDOW    (WINDOW),
    .CNT_W     (CNT_W),
    .AVG_SHIFT (AVG_SHIFT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .spike_in (spike_in),
    .rate_if  (rate_if),
    .avg_out  (avg_out),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkSample(input string tag, input int v, input int o, input int s,
                             input int a, input int ov);
    checkOutput({tag, ".valid"},   rate_if.rate_valid, v);
    checkOutput({tag, ".rate"},    rate_if.rate_out,   o);
    checkOutput({tag, ".sat"},     rate_if.rate_sat,   s);
    checkOutput({tag, ".avg"},     avg_out,            a);
    checkOutput({tag, ".overrun"}, overrun,            ov);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one spike_in value per cycle from the current pattern, then advance a cycle.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      case (spikeMode)
        SPK_EVERY8: spike_in = ((phaseCnt % 8) == 0);
        SPK_HIGH:   spike_in = 1'b1;
        default:    spike_in = 1'b0;
      endcase
      phaseCnt++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    enable             = 1'b0;
    spike_in           = 1'b0;
    rate_if.rate_ready = 1'b1;
    step();
    step();
    checkSample("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Steady rate: 32 spikes per window, EMA 8, 14, 18, 21
    enable    = 1'b1;
    spikeMode = SPK_EVERY8;
    phaseCnt  = 0;
    applyStimulus(257);
    checkSample("steady1", 1, 32, 0, 8, 0);
    applyStimulus(1);
    checkOutput("steady1.consumed", rate_if.rate_valid, 0);
    applyStimulus(255);
    checkSample("steady2", 1, 32, 0, 14, 0);
    applyStimulus(256);
    checkSample("steady3", 1, 32, 0, 18, 0);
    applyStimulus(256);
    checkSample("steady4", 1, 32, 0, 21, 0);

    // Saturation, then an empty window (EMA step on a negative error)
    spikeMode = SPK_HIGH;
    applyStimulus(256);
    checkSample("sat.full", 1, 255, 1, 79, 0);
    spikeMode = SPK_LOW;
    applyStimulus(256);
    checkSample("sat.empty", 1, 0, 0, 59, 0);

    // Pass-through: buffer full with ready high on the closing cycle
    spikeMode = SPK_EVERY8;
    applyStimulus(1);
    rate_if.rate_ready = 1'b0;
    applyStimulus(255);
    checkSample("pt.first", 1, 32, 0, 52, 0);
    spikeMode = SPK_HIGH;
    applyStimulus(255);
    checkSample("pt.hold", 1, 32, 0, 52, 0);
    rate_if.rate_ready = 1'b1;
    applyStimulus(1);
    checkSample("pt.load", 1, 255, 1, 102, 0);
    spikeMode = SPK_EVERY8;
    applyStimulus(1);
    checkOutput("pt.consumed", rate_if.rate_valid, 0);

    // Backpressure across two closures: second sample dropped, overrun sticks
    rate_if.rate_ready = 1'b0;
    applyStimulus(255);
    checkSample("bp.first", 1, 32, 0, 84, 0);
    spikeMode = SPK_LOW;
    applyStimulus(128);
    checkSample("bp.hold", 1, 32, 0, 84, 0);
    applyStimulus(128);
    checkSample("bp.drop", 1, 32, 0, 63, 1);
    rate_if.rate_ready = 1'b1;
    applyStimulus(1);
    checkOutput("bp.consumed", rate_if.rate_valid, 0);
    checkOutput("bp.sticky", overrun, 1);

    // Spike on the closing cycle belongs to the old window, the next one to the new window
    applyStimulus(254);
    spike_in = 1'b1;
    step();
    checkSample("edge.old", 1, 1, 0, 47, 1);
    step();
    applyStimulus(255);
    checkSample("edge.new", 1, 1, 0, 35, 1);

    // Drop enable at win_cnt=100: no sample, buffer and EMA untouched
    spikeMode = SPK_EVERY8;
    applyStimulus(100);
    enable = 1'b0;
    applyStimulus(300);
    checkSample("disable", 0, 1, 0, 35, 1);

    // Re-enable restarts the window from zero
    enable = 1'b1;
    applyStimulus(256);
    checkOutput("reen.early", rate_if.rate_valid, 0);
    applyStimulus(1);
    checkSample("reen", 1, 32, 0, 34, 1);

    // Synchronous reset with a pending sample and overrun set
    rate_if.rate_ready = 1'b0;
    reset = 1'b1;
    step();
    checkSample("rst.mid", 0, 0, 0, 0, 0);
    reset              = 1'b0;
    rate_if.rate_ready = 1'b1;
    applyStimulus(256);
    checkOutput("rst.early", rate_if.rate_valid, 0);
    applyStimulus(1);
    checkSample("rst.after", 1, 32, 0, 8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
